// File: rtl/halflife_pkg.sv
// Shared types and default sizes for the half-life decay counter.
package halflife_pkg;

  // Counter operating mode as driven on the mode input.
  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_UP    = 2'b01,
    MODE_DOWN  = 2'b10,
    MODE_DECAY = 2'b11
  } mode_e;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_PRESCALE_W = 16;

endpackage

// File: rtl/halflife_prescaler.sv
// Half-life period prescaler.
// Counts enabled ticks and flags the tick that completes a period.
//   clk, rst_n  : clock, async active-low reset
//   clr         : force the count to 0 (wins over tick_en)
//   tick_en     : advance the count on this edge
//   period      : period length in ticks; 0 behaves as 1
//   terminal_c  : high on the tick that ends the current period (combinational)
module halflife_prescaler
  import halflife_pkg::*;
#(
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  tick_en,
  input  logic [PRESCALE_W-1:0] period,
  output logic                  terminal_c
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;
  logic [PRESCALE_W-1:0] last_c;

  // >= rather than == so a period shrunk below the current count still ends.
  always_comb begin
    last_c     = (period == '0) ? '0 : period - PRESCALE_W'(1);
    terminal_c = tick_en && !clr && (cnt_q >= last_c);
    cnt_d      = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick_en) begin
      cnt_d = terminal_c ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/halflife_decay_counter.sv
// Load/up/down counter with optional saturation and an exponential decay mode
// that halves the value once per programmable number of enabled cycles.
//   clk, rst_n  : clock, async active-low reset
//   en          : qualifies up/down/decay steps
//   load        : synchronous load of load_val (highest priority)
//   load_val    : value written on load
//   mode        : 00 hold, 01 up, 10 down, 11 decay
//   period      : half-life length in enabled cycles (0 treated as 1)
//   count       : registered counter value
//   zero        : count == 0
//   half_pulse  : registered one-cycle pulse per decay halving
//   done_pulse  : registered one-cycle pulse when a step lands on 0
//   busy        : decay mode in effect and count != 0
module halflife_decay_counter
  import halflife_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] period,
  output logic [WIDTH-1:0]      count,
  output logic                  zero,
  output logic                  half_pulse,
  output logic                  done_pulse,
  output logic                  busy
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  mode_e            mode_c;
  mode_e            mode_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             half_q;
  logic             half_d;
  logic             done_q;
  logic             done_d;
  logic             decay_live_c;
  logic             pre_clr_c;
  logic             pre_tick_c;
  logic             halve_c;

  assign mode_c = mode_e'(mode);

  // Prescaler runs only in decay with a non-zero count; otherwise parked at 0
  // so entering decay (or loading) always restarts a full period.
  assign decay_live_c = (mode_c == MODE_DECAY) && (count_q != '0);
  assign pre_clr_c    = load || !decay_live_c;
  assign pre_tick_c   = en && decay_live_c;

  halflife_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pre_clr_c),
    .tick_en    (pre_tick_c),
    .period     (period),
    .terminal_c (halve_c)
  );

  // Next count and pulse selection: load > enabled step > hold.
  always_comb begin
    count_d = count_q;
    half_d  = 1'b0;
    done_d  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      case (mode_c)
        MODE_UP: begin
          if (count_q == CNT_MAX) begin
            count_d = SATURATE ? CNT_MAX : '0;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (count_q == '0) begin
            count_d = SATURATE ? '0 : CNT_MAX;
          end else begin
            count_d = count_q - WIDTH'(1);
            done_d  = (count_q == WIDTH'(1));
          end
        end
        MODE_DECAY: begin
          if (halve_c) begin
            count_d = count_q >> 1;
            half_d  = 1'b1;
            done_d  = (count_q == WIDTH'(1));
          end
        end
        default: ;
      endcase
    end
  end

  // Mode is registered so busy carries no combinational path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      half_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= MODE_HOLD;
    end else begin
      count_q <= count_d;
      half_q  <= half_d;
      done_q  <= done_d;
      mode_q  <= mode_c;
    end
  end

  assign count      = count_q;
  assign zero       = (count_q == '0);
  assign half_pulse = half_q;
  assign done_pulse = done_q;
  assign busy       = (mode_q == MODE_DECAY) && (count_q != '0);

endmodule

// File: tb/tb_halflife_decay_counter.sv
// Bench for halflife_decay_counter: one saturating and one wrapping instance
// share the same stimulus and are compared against an arithmetic model.
module tb_halflife_decay_counter;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 16;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          load;
  logic [W-1:0]  load_val;
  logic [1:0]    mode;
  logic [PW-1:0] period;

  logic [W-1:0] cnt_s, cnt_w;
  logic         zero_s, zero_w, half_s, half_w, done_s, done_w, busy_s, busy_w;

  halflife_decay_counter #(.WIDTH(W), .PRESCALE_W(PW), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .period(period), .count(cnt_s), .zero(zero_s),
    .half_pulse(half_s), .done_pulse(done_s), .busy(busy_s)
  );

  halflife_decay_counter #(.WIDTH(W), .PRESCALE_W(PW), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .period(period), .count(cnt_w), .zero(zero_w),
    .half_pulse(half_w), .done_pulse(done_w), .busy(busy_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: index 0 saturating, index 1 wrapping.
  int m_cnt[2];
  int m_pre[2];
  bit m_half[2];
  bit m_done[2];
  int m_mode_seen;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_pre[k] = 0; m_half[k] = 0; m_done[k] = 0;
    end
    m_mode_seen = 0;
  endtask

  // Applies the behavioural rules to one edge, using the inputs present at it.
  task automatic model_edge();
    int eff;
    int old;
    eff = (period == 0) ? 1 : int'(period);
    for (int k = 0; k < 2; k++) begin
      old       = m_cnt[k];
      m_half[k] = 0;
      m_done[k] = 0;
      if (load) begin
        m_cnt[k] = int'(load_val);
        m_pre[k] = 0;
      end else begin
        if (en && mode == 2'd1) begin
          if (k == 0) m_cnt[k] = (old == 255) ? 255 : old + 1;
          else        m_cnt[k] = (old + 1) % 256;
        end else if (en && mode == 2'd2) begin
          if (k == 0) m_cnt[k] = (old == 0) ? 0 : old - 1;
          else        m_cnt[k] = (old + 255) % 256;
          m_done[k] = (old == 1);
        end
        if (mode != 2'd3 || old == 0) begin
          m_pre[k] = 0;
        end else if (en) begin
          if (m_pre[k] + 1 >= eff) begin
            m_pre[k]  = 0;
            m_cnt[k]  = old / 2;
            m_half[k] = 1;
            m_done[k] = (old == 1);
          end else begin
            m_pre[k] = m_pre[k] + 1;
          end
        end
      end
    end
    m_mode_seen = int'(mode);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " sat count"}, int'(cnt_s), m_cnt[0]);
    chk({tag, " sat zero"},  int'(zero_s), int'(m_cnt[0] == 0));
    chk({tag, " sat half"},  int'(half_s), int'(m_half[0]));
    chk({tag, " sat done"},  int'(done_s), int'(m_done[0]));
    chk({tag, " sat busy"},  int'(busy_s), int'(m_mode_seen == 3 && m_cnt[0] != 0));
    chk({tag, " wrap count"}, int'(cnt_w), m_cnt[1]);
    chk({tag, " wrap zero"},  int'(zero_w), int'(m_cnt[1] == 0));
    chk({tag, " wrap half"},  int'(half_w), int'(m_half[1]));
    chk({tag, " wrap done"},  int'(done_w), int'(m_done[1]));
    chk({tag, " wrap busy"},  int'(busy_w), int'(m_mode_seen == 3 && m_cnt[1] != 0));
  endtask

  task automatic set_in(input bit e, input bit l, input int lv, input int m, input int p);
    en = e; load = l; load_val = W'(lv); mode = 2'(m); period = PW'(p);
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit         en;
    bit         load;
    logic [7:0] lv;
    logic [1:0] mode;
    int         period;
    logic [7:0] exp_cnt;
    bit         exp_half;
    bit         exp_done;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int hcount;
    set_in(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #12;
    check_model("reset");
    rst_n = 1'b1;

    // Saturating up/down and load-of-zero vectors (sat instance expectations).
    vecs = '{
      '{1, 1, 8'hFE, 2'd1, 0, 8'hFE, 0, 0},
      '{1, 0, 8'h00, 2'd1, 0, 8'hFF, 0, 0},
      '{1, 0, 8'h00, 2'd1, 0, 8'hFF, 0, 0},
      '{1, 0, 8'h00, 2'd1, 0, 8'hFF, 0, 0},
      '{1, 1, 8'h02, 2'd2, 0, 8'h02, 0, 0},
      '{1, 0, 8'h00, 2'd2, 0, 8'h01, 0, 0},
      '{1, 0, 8'h00, 2'd2, 0, 8'h00, 0, 1},
      '{1, 0, 8'h00, 2'd2, 0, 8'h00, 0, 0},
      '{1, 1, 8'h00, 2'd3, 0, 8'h00, 0, 0},
      '{1, 0, 8'h00, 2'd3, 0, 8'h00, 0, 0},
      '{0, 0, 8'h00, 2'd1, 0, 8'h00, 0, 0}
    };
    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].en, vecs[i].load, int'(vecs[i].lv), int'(vecs[i].mode), vecs[i].period);
      cycle("vec");
      chk($sformatf("vec%0d count", i), int'(cnt_s), int'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d half", i),  int'(half_s), int'(vecs[i].exp_half));
      chk($sformatf("vec%0d done", i),  int'(done_s), int'(vecs[i].exp_done));
    end

    // Wrapping instance: 0xFF up goes to 0 without done.
    set_in(1, 1, 8'hFF, 1, 0); cycle("wrapld");
    set_in(1, 0, 0, 1, 0);     cycle("wrapup");
    chk("wrap ff->00 count", int'(cnt_w), 0);
    chk("wrap ff->00 done", int'(done_w), 0);

    // Decay 0x40 with period 4: halving on every 4th edge, seven in total.
    set_in(1, 1, 8'h40, 3, 4); cycle("dload");
    set_in(1, 0, 0, 3, 4);
    hcount = 0;
    for (int i = 1; i <= 28; i++) begin
      cycle("decay");
      chk($sformatf("decay e%0d count", i), int'(cnt_s), 8'h40 >> (i / 4));
      chk($sformatf("decay e%0d half", i), int'(half_s), int'(i % 4 == 0));
      chk($sformatf("decay e%0d done", i), int'(done_s), int'(i == 28));
      hcount += int'(half_s);
    end
    chk("decay half count", hcount, 7);
    chk("decay busy end", int'(busy_s), 0);

    // Period 0 acts as 1.
    set_in(1, 1, 8'h08, 3, 0); cycle("p0ld");
    set_in(1, 0, 0, 3, 0);
    for (int i = 1; i <= 4; i++) begin
      cycle("p0");
      chk($sformatf("p0 e%0d count", i), int'(cnt_s), 8 >> i);
    end

    // Period 3 with an en=0 gap: halving slips by one edge.
    set_in(1, 1, 8'h40, 3, 3); cycle("engld");
    set_in(1, 0, 0, 3, 3); cycle("eng1");
    set_in(0, 0, 0, 3, 3); cycle("eng2");
    set_in(1, 0, 0, 3, 3); cycle("eng3");
    chk("en gap no half yet", int'(half_s), 0);
    cycle("eng4");
    chk("en gap half", int'(half_s), 1);
    chk("en gap count", int'(cnt_s), 8'h20);

    // Prescaler at 5 with period 8, then period 2: halve on the next edge.
    set_in(1, 1, 8'h80, 3, 8); cycle("pcld");
    set_in(1, 0, 0, 3, 8);
    for (int i = 0; i < 5; i++) cycle("pc");
    set_in(1, 0, 0, 3, 2); cycle("pcnew");
    chk("period shrink half", int'(half_s), 1);
    chk("period shrink count", int'(cnt_s), 8'h40);

    // Hold for 2 cycles mid-period, then a full new period before halving.
    set_in(1, 0, 0, 3, 4); cycle("hd1"); cycle("hd2");
    set_in(1, 0, 0, 0, 4); cycle("hh1"); cycle("hh2");
    set_in(1, 0, 0, 3, 4);
    for (int i = 1; i <= 4; i++) begin
      cycle("hre");
      chk($sformatf("reenter e%0d half", i), int'(half_s), int'(i == 4));
    end

    // Load while the prescaler sits at period-1.
    set_in(1, 1, 8'h20, 3, 4); cycle("lbld");
    set_in(1, 0, 0, 3, 4);
    for (int i = 0; i < 3; i++) cycle("lb");
    set_in(1, 1, 8'h10, 3, 4); cycle("lbload");
    chk("load busy count", int'(cnt_s), 8'h10);
    chk("load busy half", int'(half_s), 0);
    set_in(1, 0, 0, 3, 4);
    for (int i = 1; i <= 4; i++) begin
      cycle("lbpost");
      chk($sformatf("load busy e%0d half", i), int'(half_s), int'(i == 4));
    end

    // Randomised run against the model.
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
             int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 6)));
      cycle("rand");
    end

    // Asynchronous reset mid-count.
    set_in(1, 1, 8'h33, 1, 0); cycle("rstld");
    set_in(1, 0, 0, 1, 0); cycle("rstup");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async rst count", int'(cnt_s), 0);
    chk("async rst zero", int'(zero_s), 1);
    check_model("async rst");
    #1 rst_n = 1'b1;

    // Load after reset: 0xA5, no pulses.
    set_in(0, 1, 8'hA5, 0, 0); cycle("postrst");
    chk("post rst load", int'(cnt_s), 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/halflife_decay_counter.md
Name: halflife_decay_counter

Overview:
- Parametrised successor to the team's 4-bit load/up/down half-life counter.
- Generalised in width and saturation mode; adds an exponential "decay" mode in which the value halves once every programmable number of enabled cycles.
- Adds status/event outputs for the surrounding timer logic (display, compare, IRQ).
- Sits between the user-IO input decode and the output/display drivers.

Parameters:
- WIDTH, 8, count register width (>=2).
- PRESCALE_W, 16, width of the half-life period prescaler.
- SATURATE, 1: 1 = up/down clamp at max/0; 0 = modulo-2^WIDTH wrap.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; qualifies up/down/decay steps.
- load  input  1  synchronous load of load_val; has priority over en and mode.
- load_val  input  WIDTH  value written on load.
- mode  input  2  00 hold, 01 up, 10 down, 11 decay.
- period  input  PRESCALE_W  half-life length in enabled cycles; 0 is treated as 1.
- count  output  WIDTH  current value, registered.
- zero  output  1  high when count == 0 (decoded from the count register).
- half_pulse  output  1  one-cycle pulse on each decay halving step, registered.
- done_pulse  output  1  one-cycle pulse when count reaches 0 by a step, registered.
- busy  output  1  high while mode == decay and count != 0.

Behaviour:
- Reset (rst_n low, asynchronous): count = 0, prescaler = 0, half_pulse = 0, done_pulse = 0. zero is 1 and busy is 0 as a consequence.
- Per-edge priority: load > (en && mode step) > hold.
- Load: count <= load_val and prescaler <= 0. No pulses, even when load_val == 0.
- Pulse default: half_pulse and done_pulse are 0 on every edge unless set by a step below; each lasts exactly one cycle.
- Hold (mode 00) or en = 0: count unchanged. Prescaler is held while en = 0 in decay mode.
- Up (01):
  - count + 1.
  - At 2^WIDTH-1: stays there if SATURATE = 1, else wraps to 0.
  - A wrap to 0 does NOT assert done_pulse.
- Down (10):
  - count - 1.
  - At 0: stays 0 if SATURATE = 1, else wraps to 2^WIDTH-1.
  - The step from 1 to 0 asserts done_pulse on the same edge count becomes 0.
- Decay (11):
  - Prescaler increments on each enabled cycle.
  - When prescaler >= max(period,1)-1: prescaler <= 0, count <= count >> 1, half_pulse = 1.
  - If the new count is 0 (old count was 1), done_pulse = 1 as well.
  - With count == 0, the prescaler is held at 0 and no pulses occur.
  - Latency: the first halving occurs on the period-th enabled edge after load or after entering decay.
- Mode change: prescaler <= 0 on any edge where mode != 11, so re-entering decay restarts a full period.
- Period change mid-run: the >= compare guarantees termination. If a period smaller than the current prescaler value is written, a halving occurs on the next enabled edge.
- Load while busy: the load wins and the prescaler restarts; no pulses are issued on that edge.
- Reset mid-operation: immediate return to reset values, independent of clk.
- No combinational path from inputs to outputs; only zero and busy are decoded from registers.

Decomposition:
- Package halflife_pkg:
  - mode enum (MODE_HOLD, MODE_UP, MODE_DOWN, MODE_DECAY, 2 bits).
  - Default width constants.
- Sub-module halflife_prescaler (PRESCALE_W):
  - Inputs: clk, rst_n, clr, tick_en, period.
  - Output: terminal pulse.
  - Contains the >= compare and the period-0 handling.
- The top level holds the count register, the mode mux, saturation logic and pulse registers.

Test Plan:
- Reset/load: WIDTH=8. Assert rst_n low mid-count → count=0, zero=1 immediately. Then load=1, load_val=0xA5 → count=0xA5 next edge, no pulses.
- Up/down saturation:
  - SATURATE=1: load 0xFE, mode up, en for 3 cycles → 0xFF, 0xFF, 0xFF.
  - Load 0x02, mode down → 0x01, 0x00 with done_pulse on the 0x00 edge, then 0x00 with no further pulse.
  - SATURATE=0: 0xFF up → 0x00 with no done_pulse.
- Decay sequence: period=4, load 0x40, mode decay, en=1 → count halves every 4th edge: 0x20, 0x10, 0x08, 0x04, 0x02, 0x01, 0x00. Seven half_pulses; done_pulse only with the final one; busy falls when count hits 0.
- en gating and period=0: period=0 → halving every enabled edge. Toggle en 1,0,1 with period=3 → the 3rd halving edge is delayed by the en=0 cycles.
- Mid-run changes:
  - Prescaler at 5 with period=8, write period=2 → halving on the next edge.
  - Switch to hold for 2 cycles, then back to decay → a full new period before the next halving.
- Load during decay: load 0x10 while the prescaler is at period-1 → count=0x10, no half_pulse, next halving a full period later.
